radar_scan_sequencer: RTL

Top-level scan scheduler for the step-and-stare radar platform. It sequences the horizontal slip motor controller and the vertical step motor controller through a raster of horizontal lines. Each line is one full horizontal slip run, followed by a settle delay and one vertical step. The block supports serpentine direction reversal, a per-move watchdog and abort. It sits between the host register bank and the two motor controllers and owns their start, direction and force-stop inputs.

---
 rtl/radar_scan_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/radar_scan_sequencer.sv
// -----------------------------------------------------------------------------
// radar_scan_sequencer
//
// Raster scan scheduler for the step-and-stare radar platform. Each raster line
// is one horizontal slip run, a settle delay, then one vertical step. The last
// line ends after its horizontal run. The block supports serpentine direction
// reversal, a per-move watchdog and an abort. It owns the start, direction and
// force-stop inputs of both motor controllers.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   scan_start          request to begin a scan (accepted only when idle)
//   scan_abort          request to stop the current scan immediately
//   cfg_*               scan configuration, captured when a scan is accepted
//   h_done, v_done      move-complete pulses from the motor controllers
//   h_start, h_dir      horizontal start pulse and direction
//   v_start, v_dir      vertical start pulse and direction
//   h/v_force_stop      one-cycle force-stop pulses on abort or timeout
//   busy, line_idx      scan in progress, index of the current line
//   scan_done           one-cycle pulse on normal completion
//   scan_aborted        one-cycle pulse when an abort is taken
//   err_timeout         sticky watchdog error, cleared by the next scan
// -----------------------------------------------------------------------------
module radar_scan_sequencer #(
  parameter int CNT_W  = 32,
  parameter int LINE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_start,
  input  logic              scan_abort,
  input  logic [LINE_W-1:0] cfg_lines,
  input  logic [CNT_W-1:0]  cfg_settle_cycles,
  input  logic [CNT_W-1:0]  cfg_timeout_cycles,
  input  logic              cfg_serpentine,
  input  logic              cfg_h_dir0,
  input  logic              cfg_v_dir,
  input  logic              h_done,
  input  logic              v_done,
  output logic              h_start,
  output logic              h_dir,
  output logic              h_force_stop,
  output logic              v_start,
  output logic              v_dir,
  output logic              v_force_stop,
  output logic              busy,
  output logic [LINE_W-1:0] line_idx,
  output logic              scan_done,
  output logic              scan_aborted,
  output logic              err_timeout
);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [LINE_W-1:0] LINE_ZERO = {LINE_W{1'b0}};
  localparam logic [LINE_W-1:0] LINE_ONE  = {{(LINE_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_H_START = 3'd1,
    S_H_WAIT  = 3'd2,
    S_SETTLE  = 3'd3,
    S_V_START = 3'd4,
    S_V_WAIT  = 3'd5,
    S_DONE    = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  state_t state_q, state_d;

  // Configuration shadows (the start direction is held directly in h_dir_q).
  logic [LINE_W-1:0] lines_sh_q, lines_sh_d;
  logic [CNT_W-1:0]  settle_sh_q, settle_sh_d;
  logic [CNT_W-1:0]  timeout_sh_q, timeout_sh_d;
  logic              serp_sh_q, serp_sh_d;
  logic              v_dir_sh_q, v_dir_sh_d;

  logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              halt_abort_q, halt_abort_d;

  logic              h_start_q, h_start_d;
  logic              h_dir_q, h_dir_d;
  logic              h_force_stop_q, h_force_stop_d;
  logic              v_start_q, v_start_d;
  logic              v_dir_q, v_dir_d;
  logic              v_force_stop_q, v_force_stop_d;
  logic              busy_q, busy_d;
  logic [LINE_W-1:0] line_idx_q, line_idx_d;
  logic              scan_done_q, scan_done_d;
  logic              scan_aborted_q, scan_aborted_d;
  logic              err_timeout_q, err_timeout_d;

  logic              accept;
  logic              abort_take;
  logic              in_wait;
  logic [CNT_W-1:0]  wdog_inc;
  logic              wdog_expire;
  logic [CNT_W:0]    settle_inc;
  logic              settle_go;
  logic              last_line;
  logic              timeout_hit;

  assign accept      = (state_q == S_IDLE) && scan_start;
  // HALT already drives the force-stops, so a second abort there is not re-taken.
  assign abort_take  = scan_abort && (state_q != S_IDLE) && (state_q != S_HALT);
  assign in_wait     = (state_q == S_H_WAIT) || (state_q == S_V_WAIT);
  // The watchdog saturates. The incremented value is compared, so expiry falls
  // on the edge that ends the Nth waiting cycle.
  assign wdog_inc    = (wdog_q == CNT_MAX) ? wdog_q : (wdog_q + CNT_ONE);
  assign wdog_expire = in_wait && (timeout_sh_q != CNT_ZERO) && (wdog_inc == timeout_sh_q);
  // The settle counter is one bit wider so that it cannot overflow.
  // A zero setting still spends the single entry cycle in SETTLE.
  assign settle_inc  = {1'b0, settle_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign settle_go   = (settle_inc >= {1'b0, settle_sh_q});
  assign last_line   = (line_idx_q == (lines_sh_q - LINE_ONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks every other transition
  always_comb begin
    state_d = state_q;
    if (abort_take) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (scan_start) begin
            state_d = (cfg_lines == LINE_ZERO) ? S_DONE : S_H_START;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_H_START: state_d = S_H_WAIT;
        S_H_WAIT: begin
          if (h_done) begin
            state_d = last_line ? S_DONE : S_SETTLE;
          end else if (wdog_expire) begin
            state_d = S_HALT;
          end else begin
            state_d = S_H_WAIT;
          end
        end
        S_SETTLE:  state_d = settle_go ? S_V_START : S_SETTLE;
        S_V_START: state_d = S_V_WAIT;
        S_V_WAIT: begin
          if (v_done) begin
            state_d = S_H_START;
          end else if (wdog_expire) begin
            state_d = S_HALT;
          end else begin
            state_d = S_V_WAIT;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_HALT:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: configuration capture, counters, line index, direction, error flag
  always_comb begin
    // Without an abort, HALT can only be entered through the watchdog.
    timeout_hit = (state_d == S_HALT) && !abort_take;

    if (accept) begin
      lines_sh_d    = cfg_lines;
      settle_sh_d   = cfg_settle_cycles;
      timeout_sh_d  = cfg_timeout_cycles;
      serp_sh_d     = cfg_serpentine;
      v_dir_sh_d    = cfg_v_dir;
      line_idx_d    = LINE_ZERO;
      h_dir_d       = cfg_h_dir0;
      err_timeout_d = 1'b0;
    end else begin
      lines_sh_d   = lines_sh_q;
      settle_sh_d  = settle_sh_q;
      timeout_sh_d = timeout_sh_q;
      serp_sh_d    = serp_sh_q;
      v_dir_sh_d   = v_dir_sh_q;
      if ((state_q == S_V_WAIT) && v_done && !abort_take) begin
        line_idx_d = line_idx_q + LINE_ONE;
        h_dir_d    = serp_sh_q ? ~h_dir_q : h_dir_q;
      end else begin
        line_idx_d = line_idx_q;
        h_dir_d    = h_dir_q;
      end
      if (timeout_hit) begin
        err_timeout_d = 1'b1;
      end else begin
        err_timeout_d = err_timeout_q;
      end
    end

    if (state_q == S_SETTLE) begin
      settle_cnt_d = settle_inc[CNT_W-1:0];
    end else begin
      settle_cnt_d = CNT_ZERO;
    end

    if (in_wait) begin
      wdog_d = wdog_inc;
    end else begin
      wdog_d = CNT_ZERO;
    end

    // Records the cause of HALT so that scan_aborted pulses only for aborts.
    if (state_d == S_HALT) begin
      halt_abort_d = abort_take;
    end else begin
      halt_abort_d = 1'b0;
    end
  end

  // Output logic. Start pulses look ahead so that they coincide with their
  // state. Completion and force-stop pulses fire on the edge that leaves
  // DONE or HALT.
  always_comb begin
    h_start_d      = (state_d == S_H_START);
    v_start_d      = (state_d == S_V_START);
    h_force_stop_d = (state_q == S_HALT);
    v_force_stop_d = (state_q == S_HALT);
    scan_aborted_d = (state_q == S_HALT) && halt_abort_q;
    scan_done_d    = (state_q == S_DONE) && !abort_take;
    busy_d         = (state_d != S_IDLE);
    if (accept) begin
      v_dir_d = cfg_v_dir;
    end else if (busy_q) begin
      v_dir_d = v_dir_sh_q;
    end else begin
      v_dir_d = v_dir_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lines_sh_q     <= LINE_ZERO;
      settle_sh_q    <= CNT_ZERO;
      timeout_sh_q   <= CNT_ZERO;
      serp_sh_q      <= 1'b0;
      v_dir_sh_q     <= 1'b0;
      settle_cnt_q   <= CNT_ZERO;
      wdog_q         <= CNT_ZERO;
      halt_abort_q   <= 1'b0;
      h_start_q      <= 1'b0;
      h_dir_q        <= 1'b0;
      h_force_stop_q <= 1'b0;
      v_start_q      <= 1'b0;
      v_dir_q        <= 1'b0;
      v_force_stop_q <= 1'b0;
      busy_q         <= 1'b0;
      line_idx_q     <= LINE_ZERO;
      scan_done_q    <= 1'b0;
      scan_aborted_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      lines_sh_q     <= lines_sh_d;
      settle_sh_q    <= settle_sh_d;
      timeout_sh_q   <= timeout_sh_d;
      serp_sh_q      <= serp_sh_d;
      v_dir_sh_q     <= v_dir_sh_d;
      settle_cnt_q   <= settle_cnt_d;
      wdog_q         <= wdog_d;
      halt_abort_q   <= halt_abort_d;
      h_start_q      <= h_start_d;
      h_dir_q        <= h_dir_d;
      h_force_stop_q <= h_force_stop_d;
      v_start_q      <= v_start_d;
      v_dir_q        <= v_dir_d;
      v_force_stop_q <= v_force_stop_d;
      busy_q         <= busy_d;
      line_idx_q     <= line_idx_d;
      scan_done_q    <= scan_done_d;
      scan_aborted_q <= scan_aborted_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign h_start      = h_start_q;
  assign h_dir        = h_dir_q;
  assign h_force_stop = h_force_stop_q;
  assign v_start      = v_start_q;
  assign v_dir        = v_dir_q;
  assign v_force_stop = v_force_stop_q;
  assign busy         = busy_q;
  assign line_idx     = line_idx_q;
  assign scan_done    = scan_done_q;
  assign scan_aborted = scan_aborted_q;
  assign err_timeout  = err_timeout_q;

endmodule
